// File: rtl/sha256_stream_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | sha256_stream_ctrl: word-stream front-end that pads messages and      |
// | feeds 512-bit blocks to sha256_core, then captures the final digest.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sha256_stream_ctrl #(
  parameter bit MODE  = 1'b1,
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  input  logic [2:0]   s_bytes,
  output logic         core_init,
  output logic         core_next,
  output logic         core_mode,
  output logic [511:0] core_block,
  input  logic         core_ready,
  input  logic [255:0] core_digest,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_FILL  = 3'd0,
    S_PAD   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state, w_state_d;
  logic [511:0]       r_buf, w_buf_d, r_block;
  logic [3:0]         r_widx;
  logic [LEN_W-1:0]   r_len, w_len_inc;
  logic [6:0]         r_p;
  logic               r_first, r_final, r_extra, r_ext80, r_wait_first;
  logic [255:0]       r_digest;
  logic               r_digest_valid, r_busy;
  logic               w_xfer, w_core_go;
  logic [63:0]        w_len64;

  assign s_ready      = (r_state == S_FILL);
  assign w_xfer       = s_valid & s_ready;
  assign core_init    = (r_state == S_ISSUE) & r_first;
  assign core_next    = (r_state == S_ISSUE) & ~r_first;
  assign core_mode    = MODE;
  assign core_block   = r_block;
  assign digest       = r_digest;
  assign digest_valid = r_digest_valid;
  assign busy         = r_busy;
  assign w_len64      = 64'(r_len);
  assign w_len_inc    = s_last ? LEN_W'({s_bytes, 3'b000}) : LEN_W'(32);
  // The core still shows its previous ready in the first WAIT cycle.
  assign w_core_go    = ~r_wait_first & core_ready;

  always_comb begin
    w_state_d = r_state;
    w_buf_d   = r_buf;
    case (r_state)
      S_FILL: begin
        if (w_xfer) begin
          w_buf_d[9'd511 - {r_widx, 5'd0} -: 32] = s_data;
          if (s_last)
            w_state_d = S_PAD;
          else if (r_widx == 4'd15)
            w_state_d = S_ISSUE;
        end
      end
      S_PAD: begin
        for (int j = 0; j < 64; j++) begin
          if (7'(j) == r_p)
            w_buf_d[511 - 8*j -: 8] = 8'h80;
          else if (7'(j) > r_p)
            w_buf_d[511 - 8*j -: 8] = 8'h00;
        end
        if (r_p <= 7'd55)
          w_buf_d[63:0] = w_len64;
        w_state_d = S_ISSUE;
      end
      S_ISSUE: w_state_d = S_WAIT;
      S_WAIT: begin
        if (w_core_go) begin
          if (r_final) begin
            w_state_d = S_DONE;
          end else if (r_extra) begin
            w_buf_d   = {(r_ext80 ? 8'h80 : 8'h00), 440'd0, w_len64};
            w_state_d = S_ISSUE;
          end else begin
            w_buf_d   = '0;
            w_state_d = S_FILL;
          end
        end
      end
      S_DONE: begin
        w_buf_d   = '0;
        w_state_d = S_FILL;
      end
      default: w_state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= S_FILL;
      r_buf          <= '0;
      r_block        <= '0;
      r_widx         <= '0;
      r_len          <= '0;
      r_p            <= '0;
      r_first        <= 1'b1;
      r_final        <= 1'b0;
      r_extra        <= 1'b0;
      r_ext80        <= 1'b0;
      r_wait_first   <= 1'b0;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_buf          <= w_buf_d;
      r_digest_valid <= 1'b0;
      // Block register tracks the buffer only on entry to ISSUE.
      if (w_state_d == S_ISSUE)
        r_block <= w_buf_d;
      case (r_state)
        S_FILL: begin
          if (w_xfer) begin
            r_busy <= 1'b1;
            r_len  <= r_len + w_len_inc;
            r_widx <= r_widx + 4'd1;
            if (s_last)
              r_p <= 7'({r_widx, 2'b00}) + 7'(s_bytes);
          end
        end
        S_PAD: begin
          if (r_p <= 7'd55)
            r_final <= 1'b1;
          else
            r_extra <= 1'b1;
          r_ext80 <= (r_p == 7'd64);
        end
        S_ISSUE: begin
          r_first      <= 1'b0;
          r_wait_first <= 1'b1;
        end
        S_WAIT: begin
          r_wait_first <= 1'b0;
          if (w_core_go && !r_final) begin
            if (r_extra) begin
              r_final <= 1'b1;
              r_extra <= 1'b0;
            end else begin
              r_widx <= '0;
            end
          end
        end
        S_DONE: begin
          r_digest       <= core_digest;
          r_digest_valid <= 1'b1;
          r_first        <= 1'b1;
          r_len          <= '0;
          r_widx         <= '0;
          r_busy         <= 1'b0;
          r_final        <= 1'b0;
          r_extra        <= 1'b0;
          r_ext80        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_stream_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sha256_stream_ctrl: message table plus scoreboard, with a          |
// | behavioural sha256_core standing in for the real core.                |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_sha256_stream_ctrl;

  typedef logic [7:0]   byteq_t[$];
  typedef logic [511:0] blkq_t[$];
  typedef struct packed { logic first; logic [511:0] blk; } exp_blk_t;
  typedef struct {
    int kind; int len; bit gaps; bit trail; bit hold; int nblk;
    bit has_exp; logic [255:0] exp;
  } vec_t;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [31:0]  s_data = '0;
  logic [2:0]   s_bytes = '0;
  logic         core_init, core_next, core_mode, core_ready, digest_valid, busy;
  logic [511:0] core_block;
  logic [255:0] core_digest, digest;

  int n_checks = 0, n_fail = 0, cyc = 0, dig_seen = 0, msgs_sent = 0;
  exp_blk_t     exp_blk_q[$];
  logic [255:0] exp_dig_q[$];
  int           exp_nblk_q[$], exp_beat_q[$];

  sha256_stream_ctrl #(.MODE(1'b1), .LEN_W(64)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .s_bytes(s_bytes),
    .core_init(core_init), .core_next(core_next), .core_mode(core_mode),
    .core_block(core_block), .core_ready(core_ready), .core_digest(core_digest),
    .digest(digest), .digest_valid(digest_valid), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = w[t-16] + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
           + w[t-7] + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic void pad_blocks(input byteq_t msg, output blkq_t blks);
    byteq_t p;
    logic [63:0] bl;
    p  = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    blks.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      logic [511:0] v;
      for (int j = 0; j < 64; j++) v[511 - 8*j -: 8] = p[64*b + j];
      blks.push_back(v);
    end
  endfunction

  function automatic void build_msg(input int kind, input int len, output byteq_t m);
    string s56;
    s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    m.delete();
    for (int i = 0; i < len; i++) begin
      if (kind == 0)      m.push_back(8'(8'h61 + i));
      else if (kind == 2) m.push_back(s56[i]);
      else                m.push_back(8'(i * 37 + len + 5));
    end
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural core: keeps ready high one cycle past the pulse, then busy.
  logic [255:0] m_h;
  int           m_cnt;
  bit           m_pend;
  always @(posedge clk) begin
    if (!reset_n) begin
      core_ready  <= 1'b1;
      core_digest <= '0;
      m_h         <= '0;
      m_cnt       <= 0;
      m_pend      <= 1'b0;
    end else if (core_init || core_next) begin
      m_h    <= sha_compress(core_init ? IV : m_h, core_block);
      m_pend <= 1'b1;
      m_cnt  <= 3 + int'($urandom_range(0, 4));
    end else if (m_pend) begin
      core_ready <= 1'b0;
      m_pend     <= 1'b0;
    end else if (!core_ready) begin
      if (m_cnt == 0) begin
        core_ready  <= 1'b1;
        core_digest <= m_h;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Output monitor: pops scoreboard entries as the DUT produces them.
  initial begin
    bit pulse, pulse_prev, dv_prev, busy_prev, last_pend;
    int beat_cnt, pulse_cnt, last_edge;
    exp_blk_t e;
    pulse_prev = 0; dv_prev = 0; busy_prev = 0; last_pend = 0;
    beat_cnt = 0; pulse_cnt = 0; last_edge = 0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        pulse_prev = 0; dv_prev = 0; busy_prev = 0; last_pend = 0;
        beat_cnt = 0; pulse_cnt = 0;
      end else begin
        if (s_valid && s_ready) begin
          beat_cnt++;
          if (s_last) begin
            last_edge = cyc + 1;
            last_pend = 1;
            chk("beat queue nonempty", 512'(exp_beat_q.size() > 0), 512'd1);
            if (exp_beat_q.size() > 0) chk("beat count", 512'(beat_cnt), 512'(exp_beat_q.pop_front()));
            beat_cnt = 0;
          end
        end
        pulse = core_init | core_next;
        if (pulse) begin
          chk("pulse exclusive", 512'(core_init & core_next), 512'd0);
          chk("pulse width", 512'(pulse_prev), 512'd0);
          chk("s_ready at pulse", 512'(s_ready), 512'd0);
          chk("busy at pulse", 512'(busy), 512'd1);
          chk("core ready at pulse", 512'(core_ready), 512'd1);
          if (last_pend) begin
            chk("last-to-issue latency", 512'(cyc), 512'(last_edge + 1));
            last_pend = 0;
          end
          chk("block queue nonempty", 512'(exp_blk_q.size() > 0), 512'd1);
          if (exp_blk_q.size() > 0) begin
            e = exp_blk_q.pop_front();
            chk("init vs next", 512'(core_init), 512'(e.first));
            chk("core_block", core_block, e.blk);
          end
          pulse_cnt++;
        end
        if (digest_valid) begin
          chk("digest_valid width", 512'(dv_prev), 512'd0);
          chk("busy low at digest_valid", 512'(busy), 512'd0);
          chk("busy high before digest_valid", 512'(busy_prev), 512'd1);
          chk("digest queue nonempty", 512'(exp_dig_q.size() > 0), 512'd1);
          if (exp_dig_q.size() > 0) begin
            chk("digest", 512'(digest), 512'(exp_dig_q.pop_front()));
            chk("blocks per message", 512'(pulse_cnt), 512'(exp_nblk_q.pop_front()));
          end
          pulse_cnt = 0;
          dig_seen++;
        end
        pulse_prev = pulse;
        dv_prev    = digest_valid;
        busy_prev  = busy;
      end
    end
  end

  task automatic send_msg(input byteq_t msg, input bit gaps, input bit trail,
                          input int nblk, input bit has_exp, input logic [255:0] exp_dig);
    blkq_t blks;
    logic [255:0] h;
    int L, nb, t;
    bit acc;
    L = msg.size();
    pad_blocks(msg, blks);
    h = IV;
    foreach (blks[i]) begin
      exp_blk_q.push_back('{first: (i == 0), blk: blks[i]});
      h = sha_compress(h, blks[i]);
    end
    exp_dig_q.push_back(has_exp ? exp_dig : h);
    exp_nblk_q.push_back(nblk);
    if (L == 0)                  nb = 1;
    else if (trail && L % 4 == 0) nb = L / 4 + 1;
    else                         nb = (L + 3) / 4;
    exp_beat_q.push_back(nb);
    msgs_sent++;
    for (int b = 0; b < nb; b++) begin
      logic [31:0] d;
      for (int k = 0; k < 4; k++) d[31 - 8*k -: 8] = (4*b + k < L) ? msg[4*b + k] : 8'h00;
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      s_valid = 1'b1;
      s_data  = d;
      s_last  = (b == nb - 1);
      s_bytes = (b == nb - 1) ? 3'((L - 4*b) < 0 ? 0 : (L - 4*b > 4 ? 4 : L - 4*b)) : 3'd4;
      t = 0;
      do begin
        acc = s_ready;
        @(posedge clk); #1;
        t++;
      end while (!acc && t < 500);
      chk("beat accepted", 512'(acc), 512'd1);
    end
  endtask

  task automatic wait_done(input int target);
    int t;
    s_valid = 1'b0;
    s_last  = 1'b0;
    t = 0;
    while (dig_seen < target && t < 3000) begin @(posedge clk); #1; t++; end
    chk("digest arrived", 512'(dig_seen >= target), 512'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs [13];
    byteq_t m;
    int     base;
    vecs[0]  = '{0,   3, 0, 0, 0, 1, 1, 256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD};
    vecs[1]  = '{0,   0, 0, 0, 0, 1, 1, 256'hE3B0C44298FC1C149AFBF4C8996FB92427AE41E4649B934CA495991B7852B855};
    vecs[2]  = '{2,  56, 0, 0, 0, 2, 1, 256'h248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1};
    vecs[3]  = '{3,  64, 0, 0, 0, 2, 0, 256'd0};
    vecs[4]  = '{3,  64, 0, 1, 0, 2, 0, 256'd0};
    vecs[5]  = '{3,  55, 1, 0, 0, 1, 0, 256'd0};
    vecs[6]  = '{3,  57, 1, 0, 0, 2, 0, 256'd0};
    vecs[7]  = '{3,  63, 0, 0, 0, 2, 0, 256'd0};
    vecs[8]  = '{3,   1, 0, 0, 1, 1, 0, 256'd0};
    vecs[9]  = '{3, 119, 0, 0, 1, 2, 0, 256'd0};
    vecs[10] = '{3, 120, 0, 0, 1, 3, 0, 256'd0};
    vecs[11] = '{3, 128, 0, 0, 0, 3, 0, 256'd0};
    vecs[12] = '{0,   3, 1, 0, 0, 1, 1, 256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD};

    repeat (3) @(posedge clk);
    #1;
    chk("reset s_ready", 512'(s_ready), 512'd1);
    chk("reset core_init", 512'(core_init), 512'd0);
    chk("reset core_next", 512'(core_next), 512'd0);
    chk("reset core_block", core_block, 512'd0);
    chk("reset digest", 512'(digest), 512'd0);
    chk("reset digest_valid", 512'(digest_valid), 512'd0);
    chk("reset busy", 512'(busy), 512'd0);
    chk("core_mode", 512'(core_mode), 512'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 13; v++) begin
      build_msg(vecs[v].kind, vecs[v].len, m);
      send_msg(m, vecs[v].gaps, vecs[v].trail, vecs[v].nblk, vecs[v].has_exp, vecs[v].exp);
      if (!vecs[v].hold) wait_done(msgs_sent);
    end

    // Reset while the core is working on a block, then a fresh message.
    build_msg(3, 10, m);
    send_msg(m, 0, 0, 1, 0, 256'd0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid reset core_init", 512'(core_init), 512'd0);
    chk("mid reset core_next", 512'(core_next), 512'd0);
    chk("mid reset core_block", core_block, 512'd0);
    chk("mid reset digest", 512'(digest), 512'd0);
    chk("mid reset digest_valid", 512'(digest_valid), 512'd0);
    chk("mid reset busy", 512'(busy), 512'd0);
    chk("mid reset s_ready", 512'(s_ready), 512'd1);
    exp_blk_q.delete();
    exp_dig_q.delete();
    exp_nblk_q.delete();
    exp_beat_q.delete();
    msgs_sent = dig_seen;
    base      = dig_seen;
    reset_n   = 1'b1;
    @(posedge clk); #1;
    build_msg(0, 3, m);
    send_msg(m, 0, 0, 1, 1, 256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD);
    wait_done(msgs_sent);
    repeat (20) begin @(posedge clk); #1; end
    chk("digest_valid count after reset", 512'(dig_seen - base), 512'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
